nwc_stream_driver: RTL and testbench

Host-side companion to the negacyclic-convolution (NWC) processor. Accepts two polynomials as lock-stepped 30-bit coefficient streams, packs coefficient pairs into the 60-bit write words the processor consumes, issues exactly 2048 writes and a single start pulse, then captures the processor's 2048-word result burst and re-emits it as indexed coefficient pairs. One job in flight at a time.

---
 rtl/nwc_stream_driver.sv | 95 +++++++++
 tb/tb_nwc_stream_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nwc_stream_driver.sv
// nwc_stream_driver: packs lock-stepped A/B coefficient streams into NWC write words,
// fires the start pulse, then re-emits the processor's result burst as indexed pairs.
module nwc_stream_driver #(
    parameter int LOG_N   = 12,
    parameter int COEFF_W = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [COEFF_W-1:0]   a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [COEFF_W-1:0]   b_data,
    output logic                 b_ready,
    output logic [2*COEFF_W-1:0] nwc_data_in0,
    output logic [2*COEFF_W-1:0] nwc_data_in1,
    output logic                 nwc_write_enable,
    output logic                 nwc_start,
    input  logic [2*COEFF_W-1:0] nwc_data_out,
    input  logic                 nwc_output_active,
    output logic                 res_valid,
    output logic [COEFF_W-1:0]   res_lo,
    output logic [COEFF_W-1:0]   res_hi,
    output logic [LOG_N-2:0]     res_index,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;
    state_t               state;
    logic [LOG_N-1:0]     coef_cnt;
    logic [LOG_N-2:0]     word_cnt;
    logic [COEFF_W-1:0]   a_lo, b_lo;
    logic                 xfer;
    assign a_ready = state == LOAD;
    assign b_ready = state == LOAD;
    assign busy    = state != LOAD;
    assign xfer    = a_valid & b_valid & a_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= LOAD;
            coef_cnt         <= '0;
            word_cnt         <= '0;
            a_lo             <= '0;
            b_lo             <= '0;
            nwc_data_in0     <= '0;
            nwc_data_in1     <= '0;
            nwc_write_enable <= 1'b0;
            nwc_start        <= 1'b0;
            res_valid        <= 1'b0;
            res_lo           <= '0;
            res_hi           <= '0;
            res_index        <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            nwc_write_enable <= 1'b0;
            nwc_start        <= 1'b0;
            res_valid        <= 1'b0;
            done             <= 1'b0;
            // A result word outside WAIT/DRAIN is a protocol violation; it is dropped.
            if (nwc_output_active && (state == LOAD || state == START))
                err <= 1'b1;
            case (state)
                LOAD: if (xfer) begin
                    coef_cnt <= coef_cnt + LOG_N'(1);
                    if (!coef_cnt[0]) begin
                        a_lo <= a_data;
                        b_lo <= b_data;
                    end else begin
                        nwc_data_in0     <= {a_data, a_lo};
                        nwc_data_in1     <= {b_data, b_lo};
                        nwc_write_enable <= 1'b1;
                    end
                    if (&coef_cnt)
                        state <= START;
                end
                START: begin
                    nwc_start <= 1'b1;
                    state     <= WAIT;
                end
                WAIT, DRAIN: if (nwc_output_active) begin
                    res_valid <= 1'b1;
                    res_lo    <= nwc_data_out[COEFF_W-1:0];
                    res_hi    <= nwc_data_out[2*COEFF_W-1:COEFF_W];
                    res_index <= word_cnt;
                    word_cnt  <= word_cnt + (LOG_N-1)'(1);
                    done      <= &word_cnt;
                    state     <= &word_cnt ? LOAD : DRAIN;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_nwc_stream_driver.sv
// tb_nwc_stream_driver: directed load/start/drain jobs with table-checked packed words,
// stream skew, stray-result error, async reset mid-load and back-to-back jobs.
module tb_nwc_stream_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [29:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic [59:0] nwc_data_in0, nwc_data_in1;
    logic        nwc_write_enable, nwc_start;
    logic [59:0] nwc_data_out = '0;
    logic        nwc_output_active = 1'b0;
    logic        res_valid;
    logic [29:0] res_lo, res_hi;
    logic [10:0] res_index;
    logic        busy, done, err;

    nwc_stream_driver dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .nwc_data_in0(nwc_data_in0), .nwc_data_in1(nwc_data_in1),
        .nwc_write_enable(nwc_write_enable), .nwc_start(nwc_start),
        .nwc_data_out(nwc_data_out), .nwc_output_active(nwc_output_active),
        .res_valid(res_valid), .res_lo(res_lo), .res_hi(res_hi), .res_index(res_index),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wcnt = 0, wlast = 0, rv_cnt = 0;
    logic prev_we = 1'b0, prev_start = 1'b0;
    logic [59:0] w0 [2048];
    logic [59:0] w1 [2048];

    typedef struct {int k; logic [59:0] e0; logic [59:0] e1;} wvec_t;
    wvec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write/start monitor: records every packed word and polices the start pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            wcnt = 0;
            wlast = 0;
            prev_we = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (res_valid) rv_cnt++;
            if (nwc_start) begin
                chk("writes_before_start", 64'(wcnt - wlast), 64'd2048);
                chk("start_after_last_write", 64'(prev_we), 64'd1);
                chk("start_write_overlap", 64'(nwc_write_enable), 64'd0);
                chk("start_one_cycle", 64'(prev_start), 64'd0);
                wlast = wcnt;
            end
            if (nwc_write_enable) begin
                w0[wcnt % 2048] = nwc_data_in0;
                w1[wcnt % 2048] = nwc_data_in1;
                wcnt++;
            end
            prev_we = nwc_write_enable;
            prev_start = nwc_start;
        end
    end

    task automatic load(input int pa, input int pb, input int stop_at, input bit pulse_err);
        int i = 0;
        int n = 0;
        while (i < stop_at && n < 60000) begin
            @(negedge clk);
            a_valid = $urandom_range(99) < pa;
            b_valid = $urandom_range(99) < pb;
            a_data = 30'(i);
            b_data = 30'(4096 - i);
            nwc_output_active = pulse_err && i == 500;
            nwc_data_out = 60'h0abc;
            #4;
            if (a_valid && b_valid && a_ready) i++;
            n++;
        end
        chk("load_completed", 64'(i), 64'(stop_at));
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        nwc_output_active = 1'b0;
    endtask

    task automatic check_words(input string tag);
        int bad = 0;
        for (int k = 0; k < 2048; k++)
            if (w0[k] !== {30'(2*k+1), 30'(2*k)} || w1[k] !== {30'(4096-2*k-1), 30'(4096-2*k)})
                bad++;
        chk({tag, "_words_bad"}, 64'(bad), 64'd0);
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("%s_in0_w%0d", tag, tbl[t].k), 64'(w0[tbl[t].k]), 64'(tbl[t].e0));
            chk($sformatf("%s_in1_w%0d", tag, tbl[t].k), 64'(w1[tbl[t].k]), 64'(tbl[t].e1));
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!nwc_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 64'(nwc_start), 64'd1);
        chk("busy_at_start", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("wait_no_result", 64'(res_valid), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_not_ready", 64'(a_ready | b_ready), 64'd0);
    endtask

    task automatic burst();
        int bad = 0;
        nwc_output_active = 1'b1;
        nwc_data_out = {30'd1, 30'd0};
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_lo !== 30'(k) || res_hi !== 30'(k+1) ||
                res_index !== 11'(k) || done !== (k == 2047) || busy !== (k != 2047)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL result_k%0d: got v=%0b lo=%0d hi=%0d idx=%0d done=%0b busy=%0b",
                             k, res_valid, res_lo, res_hi, res_index, done, busy);
            end
            if (k == 0) chk("first_index", 64'(res_index), 64'd0);
            if (k == 1000) begin
                nwc_output_active = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("gap_no_result", 64'(res_valid), 64'd0);
                end
                chk("gap_index_hold", 64'(res_index), 64'd1000);
            end
            if (k == 2047) chk("done_index", 64'(res_index), 64'd2047);
            nwc_output_active = k < 2047;
            nwc_data_out = {30'(k+2), 30'(k+1)};
        end
        chk("result_stream_bad", 64'(bad), 64'd0);
        @(negedge clk);
        chk("post_done_busy", 64'(busy), 64'd0);
        chk("post_done_ready", 64'(a_ready & b_ready), 64'd1);
        chk("post_done_pulse", 64'(done), 64'd0);
        chk("post_done_valid", 64'(res_valid), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in0"}, 64'(nwc_data_in0), 64'd0);
        chk({tag, "_in1"}, 64'(nwc_data_in1), 64'd0);
        chk({tag, "_we_start"}, 64'({nwc_write_enable, nwc_start}), 64'd0);
        chk({tag, "_res"}, 64'({res_valid, res_lo, res_hi, res_index}), 64'd0);
        chk({tag, "_busy_done_err"}, 64'({busy, done, err}), 64'd0);
    endtask

    initial begin
        int rv0;
        tbl[0] = '{0,    {30'd1,    30'd0},    {30'd4095, 30'd4096}};
        tbl[1] = '{1,    {30'd3,    30'd2},    {30'd4093, 30'd4094}};
        tbl[2] = '{1023, {30'd2047, 30'd2046}, {30'd2049, 30'd2050}};
        tbl[3] = '{1024, {30'd2049, 30'd2048}, {30'd2047, 30'd2048}};
        tbl[4] = '{2047, {30'd4095, 30'd4094}, {30'd1,    30'd2}};
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_after_reset", 64'(a_ready & b_ready), 64'd1);

        load(100, 100, 4096, 1'b0);
        wait_start();
        check_words("job1");
        burst();

        rv0 = rv_cnt;
        load(50, 70, 4096, 1'b1);
        chk("err_sticky_after_stray", 64'(err), 64'd1);
        chk("stray_no_result", 64'(rv_cnt - rv0), 64'd0);
        wait_start();
        check_words("job2_skew");
        burst();
        chk("err_still_set", 64'(err), 64'd1);

        load(100, 100, 1000, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load(100, 100, 4096, 1'b0);
        wait_start();
        check_words("job3_after_reset");
        burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
